// File: rtl/tx_stream_arbiter.sv
// tx_stream_arbiter: packet-granular round-robin mux of NSRC AXI-stream sources onto one TX stream.
// Optional mid-packet stall timeout enabled by defining TX_ARB_TIMEOUT_EN.
module tx_stream_arbiter #(
  parameter int NSRC = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NSRC-1:0]      s_tvalid,
  output logic [NSRC-1:0]      s_tready,
  input  logic [32*NSRC-1:0]   s_tdata,
  input  logic [4*NSRC-1:0]    s_tkeep,
  input  logic [NSRC-1:0]      s_tlast,
  input  logic                 o_tready,
  output logic                 o_tvalid,
  output logic [31:0]          o_tdata,
  output logic [3:0]           o_tkeep,
  output logic                 o_tlast,
  output logic [1:0]           grant_idx,
  output logic                 busy,
  output logic [15:0]          pkt_count,
  output logic                 timeout_err
);
  typedef enum logic {IDLE, PASS} state_t;
  state_t state;
  logic sel_valid, sel_last, found, xfer;
  logic [31:0] sel_data;
  logic [3:0] sel_keep;
  logic [1:0] winner;
  always_comb begin
    sel_valid = 1'b0;
    sel_last = 1'b0;
    sel_data = '0;
    sel_keep = '0;
    s_tready = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (grant_idx == 2'(i)) begin
        sel_valid = s_tvalid[i];
        sel_last = s_tlast[i];
        sel_data = s_tdata[32*i +: 32];
        sel_keep = s_tkeep[4*i +: 4];
        s_tready[i] = busy & o_tready;
      end
    end
  end
  // search starts one past the last grant, so every source gets a turn
  always_comb begin
    winner = grant_idx;
    found = 1'b0;
    for (int k = 1; k <= NSRC; k++) begin
      if (!found && s_tvalid[(int'(grant_idx) + k) % NSRC]) begin
        winner = 2'((int'(grant_idx) + k) % NSRC);
        found = 1'b1;
      end
    end
  end
  assign busy = (state == PASS);
  assign o_tvalid = busy & sel_valid;
  assign o_tdata = o_tvalid ? sel_data : '0;
  assign o_tkeep = o_tvalid ? sel_keep : '0;
  assign o_tlast = o_tvalid & sel_last;
  assign xfer = o_tvalid & o_tready;
`ifdef TX_ARB_TIMEOUT_EN
  logic [15:0] stall;
  // only a silent granted source counts; downstream backpressure is legal
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall <= '0;
    else if (state != PASS || xfer) stall <= '0;
    else if (!sel_valid) stall <= stall + 16'd1;
  end
`else
  assign timeout_err = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant_idx <= 2'(NSRC - 1);
      pkt_count <= '0;
`ifdef TX_ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
    end else if (state == IDLE) begin
      if (found) begin
        grant_idx <= winner;
        state <= PASS;
      end
    end else if (xfer && o_tlast) begin
      state <= IDLE;
      pkt_count <= pkt_count + 16'd1;
    end
`ifdef TX_ARB_TIMEOUT_EN
    else if (!sel_valid && stall == 16'(TIMEOUT_CYCLES - 1)) begin
      state <= IDLE;
      timeout_err <= 1'b1;
    end
`endif
  end
endmodule
